// File: rtl/xeng_pkg.sv
// Shared definitions for the X-engine window scheduler and the reorder-buffer
// writer: FSM state encoding and the window geometry helpers.
package xeng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_e;

  // Words in one accumulation window (all antennas, full serial accumulation).
  function automatic int win_len(input int n_ants, input int acc_len_bits);
    return n_ants << acc_len_bits;
  endfunction

  // Width of the word counter addressing one window.
  function automatic int cnt_w(input int n_ants, input int acc_len_bits);
    return $clog2(n_ants << acc_len_bits);
  endfunction

endpackage

// File: rtl/xeng_window_sched_delay_line.sv
// Fixed-depth register pipe that lines the scheduler's vld/sync/mcnt up with
// the reorder-memory read data.
module sched_delay_line #(
  parameter int DEPTH      = 2,
  parameter int MCNT_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic                  in_sync,
  input  logic [MCNT_WIDTH-1:0] in_mcnt,
  output logic                  out_vld,
  output logic                  out_sync,
  output logic [MCNT_WIDTH-1:0] out_mcnt
);

  logic [DEPTH-1:0]      vld_sr;
  logic [DEPTH-1:0]      sync_sr;
  logic [MCNT_WIDTH-1:0] mcnt_sr [DEPTH];

  // Shift all three fields one stage per cycle; reset empties the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      sync_sr <= '0;
      for (int i = 0; i < DEPTH; i++) mcnt_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= in_vld;
      sync_sr[0] <= in_sync;
      mcnt_sr[0] <= in_mcnt;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        sync_sr[i] <= sync_sr[i-1];
        mcnt_sr[i] <= mcnt_sr[i-1];
      end
    end
  end

  assign out_vld  = vld_sr[DEPTH-1];
  assign out_sync = sync_sr[DEPTH-1];
  assign out_mcnt = mcnt_sr[DEPTH-1];

endmodule

// File: rtl/xeng_window_sched.sv
// Window scheduler between the ping-pong reorder memory and the X-engine.
// Tracks which buffer halves are full, streams one window from the chosen
// half and hands each half back to the writer once it has been read.
//
//   state | meaning
//   IDLE  | nothing streaming; leaves as soon as a buffer is pending
//   RUN   | reading one window from buffer cur, one word per cycle
//   GAP   | enforced idle time between windows (MIN_GAP cycles)
module xeng_window_sched
  import xeng_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_ANTS              = 64,
  parameter int MCNT_WIDTH          = 48,
  parameter int BRAM_LATENCY        = 2,
  parameter int MIN_GAP             = 2,
  localparam int WIN_LEN            = win_len(N_ANTS, SERIAL_ACC_LEN_BITS),
  localparam int CNT_W              = cnt_w(N_ANTS, SERIAL_ACC_LEN_BITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_done,
  input  logic                  wr_buf,
  input  logic [MCNT_WIDTH-1:0] wr_mcnt,
  output logic                  rd_en,
  output logic [CNT_W:0]        rd_addr,
  output logic                  xeng_sync,
  output logic                  xeng_vld,
  output logic [MCNT_WIDTH-1:0] xeng_mcnt,
  output logic [1:0]            buf_free,
  output logic                  busy,
  output logic [15:0]           ovf_cnt
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [GAP_W-1:0]      gap_q;
  // Buffer being streamed; between windows it is the last one served.
  // Resets to 1 so buffer 0 wins the first tie.
  logic                  cur_q;
  logic [1:0]            pend_q, pend_d;
  logic [MCNT_WIDTH-1:0] mcnt_q [2];
  logic [MCNT_WIDTH-1:0] mcnt_cur_q;
  logic [1:0]            buf_free_q;
  logic [15:0]           ovf_q;

  logic run;
  logic start;
  logic win_end;
  logic sel;
  logic overrun;

  assign run = (state_q == ST_RUN);
  // With both halves pending, alternate away from the last one served.
  assign sel = (&pend_q) ? ~cur_q : pend_q[1];
  // Refilling a half that is still queued or still being read.
  assign overrun = wr_done && (pend_q[wr_buf] || (run && (cur_q == wr_buf)));

  // Next-state decode; start/win_end mark the window boundaries.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    win_end = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
          state_d = ST_GAP;
          win_end = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Word counter, selected buffer, window mcnt and gap down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      cur_q      <= 1'b1;
      mcnt_cur_q <= '0;
      gap_q      <= '0;
    end else begin
      if (start) begin
        cur_q      <= sel;
        mcnt_cur_q <= mcnt_q[sel];
        cnt_q      <= '0;
      end else if (run) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (win_end) gap_q <= GAP_W'(MIN_GAP - 1);
      else if ((state_q == ST_GAP) && (gap_q != '0)) gap_q <= gap_q - 1'b1;
    end
  end

  // Pending flags: a new fill wins over the clear of a buffer being picked up.
  always_comb begin
    pend_d = pend_q;
    if (start)   pend_d[sel]    = 1'b0;
    if (wr_done) pend_d[wr_buf] = 1'b1;
  end

  // Per-buffer pending/mcnt capture and the saturating overrun counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      mcnt_q[0] <= '0;
      mcnt_q[1] <= '0;
      ovf_q     <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_done) mcnt_q[wr_buf] <= wr_mcnt;
      if (overrun && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
    end
  end

  // Return the half to the writer the cycle after its last word is read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          buf_free_q <= '0;
    else if (win_end) buf_free_q <= 2'b01 << cur_q;
    else              buf_free_q <= '0;
  end

  // mcnt_cur_q only changes at a window start, so after the delay the
  // X-engine mcnt switches exactly with the next window's first vld.
  sched_delay_line #(
    .DEPTH      (BRAM_LATENCY),
    .MCNT_WIDTH (MCNT_WIDTH)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (run),
    .in_sync  (run && (cnt_q == '0)),
    .in_mcnt  (mcnt_cur_q),
    .out_vld  (xeng_vld),
    .out_sync (xeng_sync),
    .out_mcnt (xeng_mcnt)
  );

  assign rd_en    = run;
  assign rd_addr  = run ? {cur_q, cnt_q} : '0;
  assign busy     = (state_q != ST_IDLE);
  assign buf_free = buf_free_q;
  assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_xeng_window_sched.sv
// Self-checking bench for xeng_window_sched: a timeline model predicts every
// output per cycle from the scheduling rules (pending halves, alternation,
// window length, gap, pipeline delay, overrun counting).
module tb_xeng_window_sched;

  localparam int ACC  = 2;
  localparam int ANTS = 4;
  localparam int MW   = 48;
  localparam int LAT  = 2;
  localparam int GAP  = 2;
  localparam int WIN  = ANTS << ACC;
  localparam int AW   = $clog2(WIN) + 1;
  localparam int RS   = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_done = 1'b0;
  logic          wr_buf = 1'b0;
  logic [MW-1:0] wr_mcnt = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          xeng_sync;
  logic          xeng_vld;
  logic [MW-1:0] xeng_mcnt;
  logic [1:0]    buf_free;
  logic          busy;
  logic [15:0]   ovf_cnt;

  xeng_window_sched #(
    .SERIAL_ACC_LEN_BITS (ACC),
    .N_ANTS              (ANTS),
    .MCNT_WIDTH          (MW),
    .BRAM_LATENCY        (LAT),
    .MIN_GAP             (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_done   (wr_done),
    .wr_buf    (wr_buf),
    .wr_mcnt   (wr_mcnt),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .xeng_sync (xeng_sync),
    .xeng_vld  (xeng_vld),
    .xeng_mcnt (xeng_mcnt),
    .buf_free  (buf_free),
    .busy      (busy),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected-output timeline, indexed by cycle modulo RS.
  bit          e_rd   [RS];
  int          e_addr [RS];
  bit          e_vld  [RS];
  bit          e_sync [RS];
  logic [MW-1:0] e_mnew [RS];
  bit          e_busy [RS];
  logic [1:0]  e_free [RS];

  bit            m_pend [2];
  logic [MW-1:0] m_mq   [2];
  int            m_last;
  int            m_cur;
  longint        m_ws, m_we, m_next;
  logic [MW-1:0] m_hold;
  int            m_ovf;
  longint        cyc = 0;
  int            served [$];

  task automatic m_reset();
    for (int i = 0; i < RS; i++) begin
      e_rd[i] = 0; e_addr[i] = 0; e_vld[i] = 0; e_sync[i] = 0;
      e_mnew[i] = '0; e_busy[i] = 0; e_free[i] = '0;
    end
    m_pend[0] = 0; m_pend[1] = 0;
    m_mq[0] = '0; m_mq[1] = '0;
    m_last = 1; m_cur = 0;
    m_ws = -1000; m_we = -1000; m_next = 0;
    m_hold = '0; m_ovf = 0;
  endtask

  task automatic check_cycle();
    int s;
    s = int'(cyc % RS);
    if (e_sync[s]) m_hold = e_mnew[s];
    chk("rd_en", rd_en, e_rd[s]);
    chk("rd_addr", rd_addr, e_rd[s] ? e_addr[s] : 0);
    chk("xeng_vld", xeng_vld, e_vld[s]);
    chk("xeng_sync", xeng_sync, e_sync[s]);
    chk("xeng_mcnt", xeng_mcnt, m_hold);
    chk("buf_free", buf_free, e_free[s]);
    chk("busy", busy, e_busy[s]);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    if (rd_en && (rd_addr[AW-2:0] == '0)) served.push_back(int'(rd_addr[AW-1]));
    e_rd[s] = 0; e_addr[s] = 0; e_vld[s] = 0; e_sync[s] = 0;
    e_busy[s] = 0; e_free[s] = '0;
  endtask

  task automatic model_cycle(input bit wd, input bit wb, input logic [MW-1:0] wm);
    bit old_p [2];
    bit ov;
    int b;
    old_p[0] = m_pend[0];
    old_p[1] = m_pend[1];
    if (cyc >= m_next && (m_pend[0] || m_pend[1])) begin
      b = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
      m_pend[b] = 0;
      m_last = b; m_cur = b;
      m_ws = cyc + 1; m_we = cyc + WIN;
      for (int k = 0; k < WIN; k++) begin
        e_rd[int'((m_ws + k) % RS)]   = 1;
        e_addr[int'((m_ws + k) % RS)] = b * WIN + k;
        e_busy[int'((m_ws + k) % RS)] = 1;
        e_vld[int'((m_ws + k + LAT) % RS)] = 1;
      end
      e_sync[int'((m_ws + LAT) % RS)] = 1;
      e_mnew[int'((m_ws + LAT) % RS)] = m_mq[b];
      e_free[int'((m_we + 1) % RS)][b] = 1'b1;
      for (int g = 1; g <= GAP; g++) e_busy[int'((m_we + g) % RS)] = 1;
      m_next = m_we + GAP + 1;
    end
    if (wd) begin
      ov = old_p[wb] || (cyc >= m_ws && cyc <= m_we && m_cur == int'(wb));
      if (ov && m_ovf < 65535) m_ovf++;
      m_pend[wb] = 1;
      m_mq[wb] = wm;
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit wd, input bit wb, input logic [MW-1:0] wm);
    check_cycle();
    model_cycle(wd, wb, wm);
    wr_done = wd; wr_buf = wb; wr_mcnt = wm;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic pulse_reset(input int n);
    wr_done = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_xeng_vld", xeng_vld, 0);
    chk("rst_xeng_sync", xeng_sync, 0);
    chk("rst_xeng_mcnt", xeng_mcnt, 0);
    chk("rst_buf_free", buf_free, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
    m_reset();
    cyc += n;
  endtask

  initial begin
    logic [MW-1:0] rm;
    bit            wd, wb;
    m_reset();
    @(negedge clk);
    pulse_reset(3);

    // Single window from buffer 0.
    idle(3);
    step(1'b1, 1'b0, 48'h10);
    idle(25);

    // Back-to-back fills of both halves.
    step(1'b1, 1'b0, 48'h1111);
    step(1'b1, 1'b1, 48'h2222);
    idle(45);

    // Both halves pending at every decision: must alternate.
    served.delete();
    for (int o = 0; o < 130; o++) begin
      wd = (o == 0) || (o == 5) || (o >= 18 && o <= 75 && ((o - 18) % 19) == 0);
      wb = (o == 0) ? 1'b0 : (o == 5) ? 1'b1 : 1'((((o - 18) / 19) + 1) % 2 == 0 ? 1 : 0);
      if (o >= 18) wb = 1'(((o - 18) / 19) % 2);
      step(wd, wb, {16'h0a17, 32'(o)});
    end
    chk("alt_windows", served.size(), 6);
    for (int i = 0; i < served.size() && i < 6; i++) chk("alt_order", served[i], i % 2);

    // Refill of a half that is still pending: overrun, second mcnt used.
    step(1'b1, 1'b1, 48'hB1);
    idle(2);
    step(1'b1, 1'b0, 48'hA0);
    step(1'b1, 1'b0, 48'hA1);
    idle(45);
    chk("ovf_one", ovf_cnt, 1);

    // Continuous refills of buffer 0: counter must saturate.
    for (int i = 0; i < 70001; i++) step(1'b1, 1'b0, {16'h0, $urandom});
    idle(40);
    chk("ovf_sat", ovf_cnt, 16'hFFFF);

    // Reset in the middle of a window, then a clean restart.
    pulse_reset(2);
    idle(3);
    step(1'b1, 1'b0, 48'h77);
    idle(8);
    chk("pre_rst_addr", rd_addr, 7);
    pulse_reset(2);
    idle(30);
    step(1'b1, 1'b0, 48'h99);
    idle(25);

    // Random fills, including overruns.
    for (int i = 0; i < 1500; i++) begin
      rm = {$urandom_range(0, 65535), $urandom};
      wd = ($urandom_range(0, 7) == 0);
      wb = 1'($urandom_range(0, 1));
      step(wd, wb, rm);
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
